// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register.
// Captures register-file operands and decoded fields and presents them to EX
// one cycle later. Resolves operands (zero register, forwarding) and decides
// when ID must stall and when a bubble enters EX.
// Build option ID_EX_FORWARD_EN:
//   defined   - EX/MEM forwarding, single-cycle load-use stall (RUN/BUBBLE FSM)
//   undefined - operands straight from the register file; ID stalls while any
//               used source is still pending in EX or MEM (FSM stays in RUN)
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [ADDR_W-1:0] id_des,
  input  logic              id_write_reg,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_write_reg,
  input  logic [ADDR_W-1:0] mem_des,
  input  logic [DATA_W-1:0] mem_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [ADDR_W-1:0] ex_des,
  output logic              ex_write_reg,
  output logic              ex_mem_read
);

  localparam logic [ADDR_W-1:0] REG_ZERO  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CTRL_W-1:0] CTRL_ZERO = {CTRL_W{1'b0}};

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  state_e            state_q,        state_d;
  logic              ex_valid_q,     ex_valid_d;
  logic [DATA_W-1:0] ex_rs_val_q,    ex_rs_val_d;
  logic [DATA_W-1:0] ex_rt_val_q,    ex_rt_val_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
  logic [ADDR_W-1:0] ex_des_q,       ex_des_d;
  logic              ex_write_reg_q, ex_write_reg_d;
  logic              ex_mem_read_q,  ex_mem_read_d;

  logic [DATA_W-1:0] rs_val_s;
  logic [DATA_W-1:0] rt_val_s;
  logic              hazard_s;
  logic              stall_s;

`ifdef ID_EX_FORWARD_EN
  logic ex_fwd_ok_s;
  logic ex_load_s;

  // Classify the EX occupant: an ALU writer can forward, a load cannot yet
  always_comb begin
    ex_fwd_ok_s = ex_valid_q & ex_write_reg_q & ~ex_mem_read_q;
    ex_load_s   = ex_valid_q & ex_mem_read_q & (ex_des_q != REG_ZERO);
  end

  // Load-use: ID needs a register the load in EX has not fetched yet
  always_comb begin
    hazard_s = ex_load_s & id_valid &
               ((id_use_rs & (id_rs == ex_des_q)) |
                (id_use_rt & (id_rt == ex_des_q)));
  end

  // Operand select: zero register, then EX result, then MEM result, then RF
  always_comb begin
    rs_val_s = rs_data;
    if (id_rs == REG_ZERO) begin
      rs_val_s = DATA_ZERO;
    end else if (ex_fwd_ok_s && (ex_des_q == id_rs)) begin
      rs_val_s = ex_result;
    end else if (mem_write_reg && (mem_des == id_rs)) begin
      rs_val_s = mem_data;
    end else begin
      rs_val_s = rs_data;
    end

    rt_val_s = rt_data;
    if (id_rt == REG_ZERO) begin
      rt_val_s = DATA_ZERO;
    end else if (ex_fwd_ok_s && (ex_des_q == id_rt)) begin
      rt_val_s = ex_result;
    end else if (mem_write_reg && (mem_des == id_rt)) begin
      rt_val_s = mem_data;
    end else begin
      rt_val_s = rt_data;
    end
  end
`else
  logic ex_pending_s;
  logic mem_pending_s;
  logic rs_busy_s;
  logic rt_busy_s;
  logic unused_fwd_s;

  // Without forwarding, any used source still being produced in EX or MEM blocks ID
  always_comb begin
    ex_pending_s  = ex_valid_q & ex_write_reg_q & (ex_des_q != REG_ZERO);
    mem_pending_s = mem_write_reg & (mem_des != REG_ZERO);
    rs_busy_s     = id_use_rs & ((ex_pending_s & (id_rs == ex_des_q)) |
                                 (mem_pending_s & (id_rs == mem_des)));
    rt_busy_s     = id_use_rt & ((ex_pending_s & (id_rt == ex_des_q)) |
                                 (mem_pending_s & (id_rt == mem_des)));
    hazard_s      = id_valid & (rs_busy_s | rt_busy_s);
  end

  // Operand select: zero register forced to 0, everything else from the RF
  always_comb begin
    rs_val_s = rs_data;
    if (id_rs == REG_ZERO) begin
      rs_val_s = DATA_ZERO;
    end else begin
      rs_val_s = rs_data;
    end

    rt_val_s = rt_data;
    if (id_rt == REG_ZERO) begin
      rt_val_s = DATA_ZERO;
    end else begin
      rt_val_s = rt_data;
    end
  end

  // Forwarding sources are not consumed in this build
  assign unused_fwd_s = ^{ex_result, mem_data};
`endif

  // Stall only from RUN; reset and redirect override any hazard
  always_comb begin
    stall_s = ~rst & ~flush & (state_q == ST_RUN) & hazard_s;
  end

  // Next EX slot contents: bubble on flush, stall or empty ID, else capture
  always_comb begin
    state_d        = ST_RUN;
    ex_valid_d     = ex_valid_q;
    ex_rs_val_d    = ex_rs_val_q;
    ex_rt_val_d    = ex_rt_val_q;
    ex_imm_d       = ex_imm_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_des_d       = ex_des_q;
    ex_write_reg_d = ex_write_reg_q;
    ex_mem_read_d  = ex_mem_read_q;

    if (flush || stall_s || !id_valid) begin
      ex_valid_d     = 1'b0;
      ex_write_reg_d = 1'b0;
      ex_mem_read_d  = 1'b0;
`ifdef ID_EX_FORWARD_EN
      if (stall_s && !flush) begin
        state_d = ST_BUBBLE;
      end else begin
        state_d = ST_RUN;
      end
`else
      state_d = ST_RUN;
`endif
    end else begin
      state_d        = ST_RUN;
      ex_valid_d     = 1'b1;
      ex_rs_val_d    = rs_val_s;
      ex_rt_val_d    = rt_val_s;
      ex_imm_d       = id_imm;
      ex_ctrl_d      = id_ctrl;
      ex_des_d       = id_des;
      ex_write_reg_d = id_write_reg;
      ex_mem_read_d  = id_mem_read;
    end
  end

  // EX slot registers and FSM state; reset dominates flush and stall
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      ex_valid_q     <= 1'b0;
      ex_rs_val_q    <= DATA_ZERO;
      ex_rt_val_q    <= DATA_ZERO;
      ex_imm_q       <= DATA_ZERO;
      ex_ctrl_q      <= CTRL_ZERO;
      ex_des_q       <= REG_ZERO;
      ex_write_reg_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ex_valid_q     <= ex_valid_d;
      ex_rs_val_q    <= ex_rs_val_d;
      ex_rt_val_q    <= ex_rt_val_d;
      ex_imm_q       <= ex_imm_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_des_q       <= ex_des_d;
      ex_write_reg_q <= ex_write_reg_d;
      ex_mem_read_q  <= ex_mem_read_d;
    end
  end

  assign stall        = stall_s;
  assign ex_valid     = ex_valid_q;
  assign ex_rs_val    = ex_rs_val_q;
  assign ex_rt_val    = ex_rt_val_q;
  assign ex_imm       = ex_imm_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_des       = ex_des_q;
  assign ex_write_reg = ex_write_reg_q;
  assign ex_mem_read  = ex_mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized bench for id_ex_stage.
// The reference model tracks what instruction sits in EX and applies the
// operand/hazard rules directly. Honors ID_EX_FORWARD_EN the same way the RTL does.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_des, mem_des;
  logic        id_use_rs, id_use_rt, id_write_reg, id_mem_read, mem_write_reg;
  logic [31:0] id_imm, rs_data, rt_data, ex_result, mem_data;
  logic [15:0] id_ctrl;

  logic        stall, ex_valid, ex_write_reg, ex_mem_read;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_des;

  int checks = 0;
  int errors = 0;

  // Reference picture of the EX slot
  logic        m_valid, m_wr, m_mr;
  logic [4:0]  m_des;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [15:0] m_ctrl;
  logic        last_stall;
  int          stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .ADDR_W(5), .CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_des(id_des), .id_write_reg(id_write_reg), .id_mem_read(id_mem_read),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .rs_data(rs_data), .rt_data(rt_data),
    .ex_result(ex_result), .mem_write_reg(mem_write_reg), .mem_des(mem_des),
    .mem_data(mem_data), .stall(stall), .ex_valid(ex_valid),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_des(ex_des), .ex_write_reg(ex_write_reg),
    .ex_mem_read(ex_mem_read)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value an instruction in ID should see for register a
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
`ifdef ID_EX_FORWARD_EN
    if (m_valid && m_wr && !m_mr && m_des == a) return ex_result;
    if (mem_write_reg && mem_des == a) return mem_data;
`endif
    return rf;
  endfunction

  // Is register a still owed by an older instruction that ID cannot get yet?
  function automatic logic owed(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return m_valid && m_mr && m_des == a;
`else
    return (m_valid && m_wr && m_des == a) || (mem_write_reg && mem_des == a);
`endif
  endfunction

  function automatic logic ref_stall();
    if (rst || flush || !id_valid) return 1'b0;
    return (id_use_rs && owed(id_rs)) || (id_use_rt && owed(id_rt));
  endfunction

  task automatic ref_update(input logic stl);
    logic [31:0] nrs, nrt;
    nrs = ref_operand(id_rs, rs_data);
    nrt = ref_operand(id_rt, rt_data);
    if (rst) begin
      m_valid = 1'b0; m_wr = 1'b0; m_mr = 1'b0; m_des = 5'd0;
      m_rs = 32'd0; m_rt = 32'd0; m_imm = 32'd0; m_ctrl = 16'd0;
    end else if (flush || !id_valid || stl) begin
      m_valid = 1'b0; m_wr = 1'b0; m_mr = 1'b0;
    end else begin
      m_valid = 1'b1; m_wr = id_write_reg; m_mr = id_mem_read; m_des = id_des;
      m_rs = nrs; m_rt = nrt; m_imm = id_imm; m_ctrl = id_ctrl;
    end
  endtask

  // One clock: check stall mid-cycle, advance model, check registered outputs
  task automatic cycle();
    logic exp_stall;
    @(negedge clk);
    exp_stall  = ref_stall();
    last_stall = stall;
    chk("stall", 32'(stall), 32'(exp_stall));
    ref_update(exp_stall);
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_write_reg", 32'(ex_write_reg), 32'(m_wr));
    chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
    chk("ex_des", 32'(ex_des), 32'(m_des));
    chk("ex_rs_val", ex_rs_val, m_rs);
    chk("ex_rt_val", ex_rt_val, m_rt);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_des = 5'd0; id_write_reg = 1'b0; id_mem_read = 1'b0;
    id_imm = 32'd0; id_ctrl = 16'd0; rs_data = 32'd0; rt_data = 32'd0;
    ex_result = 32'd0; mem_write_reg = 1'b0; mem_des = 5'd0; mem_data = 32'd0;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_stall", 32'(last_stall), 32'd0);

    // Plain capture
    idle(); id_valid = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
    rs_data = 32'h11; id_imm = 32'h5; id_ctrl = 16'hA5A5;
    cycle();
    chk("t1_valid", 32'(ex_valid), 32'd1);
    chk("t1_rs", ex_rs_val, 32'h11);
    chk("t1_imm", ex_imm, 32'h5);

    // Zero register never forwarded, never taken from RF
    idle(); id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd0; rs_data = 32'hDEAD;
    mem_write_reg = 1'b1; mem_des = 5'd0; mem_data = 32'h7;
    cycle();
    chk("zero_rs", ex_rs_val, 32'd0);

`ifdef ID_EX_FORWARD_EN
    // EX beats MEM for the same register
    idle(); id_valid = 1'b1; id_des = 5'd4; id_write_reg = 1'b1;
    cycle();
    idle(); id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd4; rs_data = 32'h1;
    ex_result = 32'hAA; mem_write_reg = 1'b1; mem_des = 5'd4; mem_data = 32'hBB;
    cycle();
    chk("ex_priority", ex_rs_val, 32'hAA);

    // Load-use: one stall, one bubble, then MEM supplies the load data
    idle(); id_valid = 1'b1; id_des = 5'd5; id_write_reg = 1'b1; id_mem_read = 1'b1;
    cycle();
    idle(); id_valid = 1'b1; id_use_rt = 1'b1; id_rt = 5'd5; rt_data = 32'h2;
    cycle();
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    mem_write_reg = 1'b1; mem_des = 5'd5; mem_data = 32'h1234;
    cycle();
    chk("lu_release", 32'(last_stall), 32'd0);
    chk("lu_rt", ex_rt_val, 32'h1234);
`else
    // ALU writer then reader: two stalled cycles while it sits in EX then MEM
    idle(); id_valid = 1'b1; id_des = 5'd6; id_write_reg = 1'b1;
    cycle();
    stall_cnt = 0;
    idle(); id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd6; rs_data = 32'h66;
    cycle();
    stall_cnt += int'(last_stall);
    chk("ns_bubble1", 32'(ex_valid), 32'd0);
    mem_write_reg = 1'b1; mem_des = 5'd6; mem_data = 32'h99;
    cycle();
    stall_cnt += int'(last_stall);
    chk("ns_bubble2", 32'(ex_valid), 32'd0);
    mem_write_reg = 1'b0; mem_des = 5'd0;
    cycle();
    chk("ns_release", 32'(last_stall), 32'd0);
    chk("ns_rs", ex_rs_val, 32'h66);
    chk("ns_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

    // Flush during a hazard: no stall, bubble, next instruction passes
    idle(); id_valid = 1'b1; id_des = 5'd5; id_write_reg = 1'b1; id_mem_read = 1'b1;
    cycle();
    idle(); id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd5; flush = 1'b1;
    cycle();
    chk("fl_stall", 32'(last_stall), 32'd0);
    chk("fl_bubble", 32'(ex_valid), 32'd0);
    idle(); id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd7; rs_data = 32'h77;
    mem_write_reg = 1'b1; mem_des = 5'd5; mem_data = 32'h55;
    cycle();
    chk("fl_next_valid", 32'(ex_valid), 32'd1);
    chk("fl_next_rs", ex_rs_val, 32'h77);

    // Reset during a hazard clears everything
    idle(); id_valid = 1'b1; id_des = 5'd5; id_write_reg = 1'b1; id_mem_read = 1'b1;
    id_imm = 32'h3C;
    cycle();
    idle(); id_valid = 1'b1; id_use_rt = 1'b1; id_rt = 5'd5; rst = 1'b1;
    cycle();
    chk("rst_stall", 32'(last_stall), 32'd0);
    chk("rst_des", 32'(ex_des), 32'd0);
    chk("rst_imm", ex_imm, 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      flush         = ($urandom_range(0, 99) < 8);
      id_valid      = ($urandom_range(0, 99) < 85);
      id_rs         = pick_reg();
      id_rt         = pick_reg();
      id_des        = pick_reg();
      id_use_rs     = ($urandom_range(0, 99) < 75);
      id_use_rt     = ($urandom_range(0, 99) < 60);
      id_mem_read   = ($urandom_range(0, 99) < 30);
      id_write_reg  = id_mem_read || ($urandom_range(0, 99) < 60);
      id_imm        = $urandom;
      id_ctrl       = 16'($urandom);
      rs_data       = $urandom;
      rt_data       = $urandom;
      ex_result     = $urandom;
      mem_write_reg = ($urandom_range(0, 99) < 50);
      mem_des       = pick_reg();
      mem_data      = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
